fetch_queue_stage: RTL and testbench

- Instruction-fetch front end. Sits directly upstream of the IF/ID pipeline register and feeds it instruction, PC and PC+4.
- Owns the fetch PC and issues word requests to program memory over a valid/ready request channel with an in-order response channel.
- Buffers returned words in a small prefetch queue.
- Accepts branch/JALR redirects from EX, flushes the queue and discards stale in-flight responses.

---
 rtl/fetch_queue_stage.sv | 150 +++++++++++++++
 tb/tb_fetch_queue_stage.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_stage.sv
// Instruction-fetch front end: owns the fetch PC, issues word requests, buffers replies in a
// prefetch queue and feeds IF/ID. Optional macro FETCH_BYPASS_EN adds an empty-queue response bypass.
module fetch_queue_stage #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int          CNT_W    = 3
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        if_valid_o,
  input  logic        if_ready_i,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_pc_plus_4_o
);

  localparam int             PW      = $clog2(DEPTH);
  localparam logic [CNT_W:0] CREDITS = (CNT_W+1)'(DEPTH);
  localparam logic [31:0]    NOP     = 32'h0000_0013;

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [31:0]      fetch_pc_reg, fetch_pc_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [CNT_W-1:0] outstanding_reg, outstanding_next;
  logic [CNT_W-1:0] drop_reg, drop_next;
  logic [PW-1:0]    q_wr_reg, q_rd_reg, tag_wr_reg, tag_rd_reg;
  logic [31:0]      last_instr_reg, last_pc_reg;

  logic [31:0] q_instr [DEPTH];
  logic [31:0] q_pc    [DEPTH];
  logic [31:0] tag_pc  [DEPTH];

  logic           rsp, issue, discard, keep, bypass, push, pop, out_fire;
  logic [CNT_W:0] credit_used;
  logic [31:0]    rsp_pc;

  // Queued entries plus in-flight requests may never exceed DEPTH, so responses always fit.
  assign rsp           = mem_rsp_valid & reset;
  assign rsp_pc        = tag_pc[tag_rd_reg];
  assign credit_used   = {1'b0, count_reg} + {1'b0, outstanding_reg};
  assign mem_req_valid = reset & ~redirect_i & (credit_used < CREDITS);
  assign mem_req_addr  = fetch_pc_reg;
  assign issue         = mem_req_valid & mem_req_ready;
  assign discard       = rsp & (state_reg == DRAIN);
  assign keep          = rsp & (state_reg == RUN);

`ifdef FETCH_BYPASS_EN
  assign bypass = keep & ~(|count_reg);
`else
  assign bypass = 1'b0;
`endif

  assign push       = keep & ~(bypass & if_ready_i);
  assign if_valid_o = (|count_reg) | bypass;
  assign out_fire   = if_valid_o & if_ready_i;
  assign pop        = out_fire & (|count_reg);

  always_comb begin
    if_instr_o = last_instr_reg;
    if_pc_o    = last_pc_reg;
    if (bypass) begin
      if_instr_o = mem_rsp_data;
      if_pc_o    = rsp_pc;
    end else if (|count_reg) begin
      if_instr_o = q_instr[q_rd_reg];
      if_pc_o    = q_pc[q_rd_reg];
    end
  end

  assign if_pc_plus_4_o = if_pc_o + 32'd4;

  always_comb begin
    state_next       = state_reg;
    fetch_pc_next    = fetch_pc_reg;
    count_next       = count_reg;
    drop_next        = drop_reg;
    outstanding_next = outstanding_reg + CNT_W'(issue) - CNT_W'(rsp);
    if (redirect_i) begin
      // Every request still in flight is now stale, except a reply landing this very cycle.
      fetch_pc_next = redirect_pc_i & 32'hFFFF_FFFC;
      count_next    = '0;
      drop_next     = outstanding_reg - CNT_W'(rsp);
    end else begin
      if (issue) fetch_pc_next = fetch_pc_reg + 32'd4;
      count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
      drop_next  = drop_reg - CNT_W'(discard);
    end
    case (state_reg)
      RUN:     if (|drop_next)  state_next = DRAIN;
      DRAIN:   if (~|drop_next) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= RUN;
      fetch_pc_reg    <= RESET_PC;
      count_reg       <= '0;
      outstanding_reg <= '0;
      drop_reg        <= '0;
      q_wr_reg        <= '0;
      q_rd_reg        <= '0;
      tag_wr_reg      <= '0;
      tag_rd_reg      <= '0;
      last_instr_reg  <= NOP;
      last_pc_reg     <= RESET_PC;
    end else begin
      state_reg       <= state_next;
      fetch_pc_reg    <= fetch_pc_next;
      count_reg       <= count_next;
      outstanding_reg <= outstanding_next;
      drop_reg        <= drop_next;
      if (redirect_i) begin
        q_wr_reg   <= '0;
        q_rd_reg   <= '0;
        tag_wr_reg <= '0;
        tag_rd_reg <= '0;
      end else begin
        if (push)  q_wr_reg   <= q_wr_reg + PW'(1);
        if (pop)   q_rd_reg   <= q_rd_reg + PW'(1);
        if (issue) tag_wr_reg <= tag_wr_reg + PW'(1);
        if (keep)  tag_rd_reg <= tag_rd_reg + PW'(1);
      end
      if (out_fire) begin
        last_instr_reg <= if_instr_o;
        last_pc_reg    <= if_pc_o;
      end
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and counters.
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[q_wr_reg] <= mem_rsp_data;
      q_pc[q_wr_reg]    <= rsp_pc;
    end
    if (issue) tag_pc[tag_wr_reg] <= fetch_pc_reg;
  end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Scoreboard bench for fetch_queue_stage: a memory model answers requests with ~addr, a monitor
// checks every IF/ID pop in order, and directed sequences cover stall, redirect and reset cases.
module tb_fetch_queue_stage;

  localparam logic [31:0] RPC = 32'h0040_0000;
`ifdef FETCH_BYPASS_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        if_valid_o, if_ready_i;
  logic [31:0] if_instr_o, if_pc_o, if_pc_plus_4_o;

  fetch_queue_stage dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .if_valid_o(if_valid_o), .if_ready_i(if_ready_i), .if_instr_o(if_instr_o),
    .if_pc_o(if_pc_o), .if_pc_plus_4_o(if_pc_plus_4_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } rsp_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          lat = 1;
  int          acc_cnt = 0;
  int          pop_cnt = 0;
  rsp_t        rsp_q[$];
  rsp_t        cur_rsp;
  logic [31:0] exp_q[$];
  logic [31:0] exp_fetch = RPC;
  logic [31:0] last_pop_pc = 32'h0;
  logic        stall_prev = 1'b0;
  logic [31:0] addr_prev = 32'h0;
  logic [31:0] exp_e;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic model_clear();
    rsp_q.delete();
    exp_q.delete();
    exp_fetch     = RPC;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'h0;
  endtask

  task automatic check_reset_vals(input string tag);
    check32({tag, "_req_valid"}, 32'(mem_req_valid), 32'd0);
    check32({tag, "_req_addr"}, mem_req_addr, RPC);
    check32({tag, "_if_valid"}, 32'(if_valid_o), 32'd0);
    check32({tag, "_if_instr"}, if_instr_o, 32'h0000_0013);
    check32({tag, "_if_pc"}, if_pc_o, RPC);
    check32({tag, "_if_pc4"}, if_pc_plus_4_o, 32'h0040_0004);
  endtask

  task automatic sync_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Memory model: records accepted requests, checks fetch order, queues expected pops.
  always @(negedge clk) begin
    if (reset) begin
      if (redirect_i) begin
        check32("req_valid_in_redirect", 32'(mem_req_valid), 32'd0);
        exp_fetch = redirect_pc_i & 32'hFFFF_FFFC;
      end
      if (mem_req_valid && mem_req_ready) begin
        check32("req_addr_order", mem_req_addr, exp_fetch);
        rsp_q.push_back('{due: cyc + lat, addr: exp_fetch});
        exp_q.push_back(exp_fetch);
        exp_fetch = exp_fetch + 32'd4;
        acc_cnt++;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'h0;
    if (reset && rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      cur_rsp       = rsp_q.pop_front();
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = ~cur_rsp.addr;
    end
  end

  // Request must stay stable while stalled.
  always @(negedge clk) begin
    if (reset && stall_prev && !redirect_i) begin
      check32("req_valid_held", 32'(mem_req_valid), 32'd1);
      check32("req_addr_held", mem_req_addr, addr_prev);
    end
    stall_prev = reset && mem_req_valid && !mem_req_ready;
    addr_prev  = mem_req_addr;
  end

  // Monitor: every pop toward IF/ID is matched against the scoreboard.
  always @(negedge clk) begin
    if (reset && if_valid_o && if_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got pc %h, required no output", if_pc_o);
      end else begin
        exp_e = exp_q.pop_front();
        check32("pop_pc", if_pc_o, exp_e);
        check32("pop_instr", if_instr_o, ~exp_e);
        check32("pop_pc4", if_pc_plus_4_o, exp_e + 32'd4);
      end
      $display("pop pc=%h instr=%h pc4=%h", if_pc_o, if_instr_o, if_pc_plus_4_o);
      last_pop_pc = if_pc_o;
      pop_cnt++;
    end
    if (reset && redirect_i) exp_q.delete();
  end

  int          lat_seen;
  int          acc0, p0;
  logic        done;
  logic [31:0] exp_pc;
  logic        pat [4];

  initial begin
    mem_req_ready = 1'b1;
    if_ready_i    = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'h0;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

    // Reset state, then first fetch latency and payload.
    #2 reset = 1'b0;
    model_clear();
    #1 check_reset_vals("rst_init");
    @(posedge clk); #1;
    reset = 1'b1;
    lat_seen = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if_valid_o) begin
        lat_seen = i;
        break;
      end
    end
    check32("first_valid_latency", 32'(lat_seen), 32'(EXP_LAT));
    check32("first_pc", if_pc_o, 32'h0040_0000);
    check32("first_pc4", if_pc_plus_4_o, 32'h0040_0004);
    check32("first_instr", if_instr_o, 32'hFFBF_FFFF);
    repeat (8) @(posedge clk);

    // IF/ID stalled for 10 cycles: credit limit caps requests at DEPTH.
    sync_reset();
    if_ready_i = 1'b0;
    acc0 = acc_cnt;
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check32("stall_req_count", 32'(acc_cnt - acc0), 32'd4);
    check32("stall_req_valid", 32'(mem_req_valid), 32'd0);
    check32("stall_if_valid", 32'(if_valid_o), 32'd1);
    @(posedge clk); #1;
    if_ready_i = 1'b1;
    p0 = pop_cnt;
    done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (pop_cnt - p0 >= 4) begin
        done = 1'b1;
        break;
      end
    end
    check32("stall_release_pops", 32'(done), 32'd1);

    // Redirect with two requests outstanding.
    sync_reset();
    lat = 4;
    acc0 = acc_cnt;
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0040_0103;
    @(negedge clk); #1;
    check32("outstanding_at_redirect", 32'(acc_cnt - acc0), 32'd2);
    @(posedge clk); #1;
    redirect_i    = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    check32("redirect_req_valid", 32'(mem_req_valid), 32'd1);
    check32("redirect_req_addr", mem_req_addr, 32'h0040_0100);
    check32("redirect_if_valid", 32'(if_valid_o), 32'd0);
    p0 = pop_cnt;
    done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      if (pop_cnt > p0) begin
        done = 1'b1;
        break;
      end
    end
    check32("redirect_pop_seen", 32'(done), 32'd1);
    check32("redirect_first_pc", last_pop_pc, 32'h0040_0100);

    // Request-ready toggling 1,0,0,1.
    lat = 1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      mem_req_ready = pat[i % 4];
    end
    @(posedge clk); #1;
    mem_req_ready = 1'b1;
    repeat (6) @(posedge clk);

    // Issue, response and pop every cycle.
    sync_reset();
    lat = 1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    exp_pc = RPC;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check32("burst_if_valid", 32'(if_valid_o), 32'd1);
      check32("burst_rsp_valid", 32'(mem_rsp_valid), 32'd1);
      check32("burst_req_valid", 32'(mem_req_valid), 32'd1);
      check32("burst_pc_step", if_pc_o, exp_pc);
      exp_pc = exp_pc + 32'd4;
    end

    // Asynchronous reset mid-burst, then restart.
    #2 reset = 1'b0;
    model_clear();
    #1 check_reset_vals("rst_async");
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check32("restart_req_valid", 32'(mem_req_valid), 32'd1);
    check32("restart_req_addr", mem_req_addr, RPC);
    repeat (6) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
